// File: rtl/strat_pkg.sv
// Shared types and constants for the strat_decide scheduler slice.
// The snapshot struct and helper keep per-symbol field selection in one place.
package strat_pkg;

    localparam int W        = 32;
    localparam int N_SYM    = 4;
    localparam int TAG_W    = 2;
    localparam int CORE_LAT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic [W-1:0] bid;
        logic [W-1:0] ask;
        logic [W-1:0] fair;
        logic [W-1:0] vol;
        logic [W-1:0] inv;
    } snap_t;

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] sym;
    } tag_t;

    // Pure selection of one symbol's fields out of the packed request buses.
    function automatic snap_t snap_pick(
        input logic [N_SYM*W-1:0] bid,
        input logic [N_SYM*W-1:0] ask,
        input logic [N_SYM*W-1:0] fair,
        input logic [N_SYM*W-1:0] vol,
        input logic [N_SYM*W-1:0] inv,
        input logic [TAG_W-1:0]   idx
    );
        snap_t s;
        s.bid  = bid[int'(idx)*W +: W];
        s.ask  = ask[int'(idx)*W +: W];
        s.fair = fair[int'(idx)*W +: W];
        s.vol  = vol[int'(idx)*W +: W];
        s.inv  = inv[int'(idx)*W +: W];
        return s;
    endfunction

endpackage

// File: rtl/strat_sched_if.sv
// Bus bundle between the symbol requesters, the strat_decide core and order entry.
// The slave modport is the scheduler's view; master is the surrounding system.
interface strat_sched_if;
    import strat_pkg::*;

    logic                 enable;
    logic                 kill;
    logic [N_SYM-1:0]     req_valid;
    logic [N_SYM-1:0]     req_ready;
    logic [N_SYM*W-1:0]   req_bid;
    logic [N_SYM*W-1:0]   req_ask;
    logic [N_SYM*W-1:0]   req_fair;
    logic [N_SYM*W-1:0]   req_vol;
    logic [N_SYM*W-1:0]   req_inv;
    logic [W-1:0]         core_bid;
    logic [W-1:0]         core_ask;
    logic [W-1:0]         core_fair;
    logic [W-1:0]         core_vol;
    logic [W-1:0]         core_inv;
    logic                 core_in_valid;
    logic                 core_buy;
    logic                 core_sell;
    logic                 core_out_valid;
    logic                 res_valid;
    logic [TAG_W-1:0]     res_sym;
    logic                 res_buy;
    logic                 res_sell;
    logic                 res_throttled;
    logic [1:0]           state_o;

    modport slave (
        input  enable, kill, req_valid, req_bid, req_ask, req_fair, req_vol, req_inv,
        input  core_buy, core_sell, core_out_valid,
        output req_ready, core_bid, core_ask, core_fair, core_vol, core_inv, core_in_valid,
        output res_valid, res_sym, res_buy, res_sell, res_throttled, state_o
    );

    modport master (
        output enable, kill, req_valid, req_bid, req_ask, req_fair, req_vol, req_inv,
        output core_buy, core_sell, core_out_valid,
        input  req_ready, core_bid, core_ask, core_fair, core_vol, core_inv, core_in_valid,
        input  res_valid, res_sym, res_buy, res_sell, res_throttled, state_o
    );

endinterface

// File: rtl/strat_rr_arb.sv
// N-way round-robin arbiter: combinational one-hot grant starting at the pointer,
// pointer advances past the granted index on every accept.
module strat_rr_arb #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [IW-1:0] ptr_r;
    logic [N-1:0]  gnt_s;
    logic [IW-1:0] gnt_idx_s;
    logic [IW-1:0] idx_s;
    logic          found_s;
    logic          hit_s;

    // Scan from the pointer and take the first requester; N is a power of 2 so the index wraps freely.
    always_comb begin
        gnt_s     = '0;
        gnt_idx_s = '0;
        idx_s     = '0;
        found_s   = 1'b0;
        hit_s     = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx_s        = ptr_r + IW'(k);
            hit_s        = en && !found_s && req[idx_s];
            gnt_s[idx_s] = gnt_s[idx_s] | hit_s;
            gnt_idx_s    = hit_s ? idx_s : gnt_idx_s;
            found_s      = found_s | hit_s;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (found_s) begin
            ptr_r <= gnt_idx_s + IW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign gnt     = gnt_s;
    assign gnt_idx = gnt_idx_s;
    assign gnt_any = found_s;

endmodule

// File: rtl/strat_sched.sv
// Time-shares one strat_decide core across N_SYM symbols: round-robin issue, symbol
// tagging through the core latency, then kill squash and a windowed order-rate limiter.
module strat_sched
    import strat_pkg::*;
#(
    parameter int RATE_WIN = 1024,
    parameter int RATE_MAX = 8
) (
    input logic          clk,
    input logic          rst,
    strat_sched_if.slave bus
);

    localparam int WIN_W = $clog2(RATE_WIN);
    localparam int RC_W  = $clog2(RATE_MAX + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(RATE_WIN - 1);
    localparam logic [RC_W-1:0]  RC_FULL  = RC_W'(RATE_MAX);

    state_t           state_r;
    logic             kill_r;
    logic [N_SYM-1:0] gnt_s;
    logic [TAG_W-1:0] gnt_idx_s;
    logic             accept_s;
    snap_t            pick_s;
    snap_t            core_r;
    logic             core_in_valid_r;
    logic [TAG_W-1:0] core_sym_r;
    tag_t             tag_r [CORE_LAT];
    logic             pipe_empty_s;
    logic [WIN_W-1:0] win_r;
    logic [RC_W-1:0]  rc_r;
    logic [RC_W-1:0]  rc_nxt_s;
    logic             hit_s;
    logic             dec_s;
    logic             squash_s;
    logic             wrap_s;
    logic             rel_s;
    logic             thr_s;
    logic             res_valid_r;
    logic [TAG_W-1:0] res_sym_r;
    logic             res_buy_r;
    logic             res_sell_r;
    logic             res_thr_r;

    strat_rr_arb #(.N(N_SYM)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (state_r == ST_RUN),
        .req     (bus.req_valid),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .gnt_any (accept_s)
    );

    assign pick_s = snap_pick(bus.req_bid, bus.req_ask, bus.req_fair, bus.req_vol,
                              bus.req_inv, gnt_idx_s);

    // Run-state FSM; kill is also registered so squashing starts the cycle after it is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            kill_r  <= 1'b0;
        end else begin
            kill_r <= bus.kill;
            case (state_r)
                ST_IDLE: begin
                    if (bus.enable && !bus.kill) state_r <= ST_RUN;
                    else                         state_r <= ST_IDLE;
                end
                ST_RUN: begin
                    if (bus.kill)         state_r <= ST_HALT;
                    else if (!bus.enable) state_r <= ST_IDLE;
                    else                  state_r <= ST_RUN;
                end
                ST_HALT: begin
                    if (!bus.kill && pipe_empty_s) state_r <= ST_IDLE;
                    else                           state_r <= ST_HALT;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Core input registers; data holds between issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_r          <= '0;
            core_in_valid_r <= 1'b0;
            core_sym_r      <= '0;
        end else begin
            core_in_valid_r <= accept_s;
            if (accept_s) begin
                core_r     <= pick_s;
                core_sym_r <= gnt_idx_s;
            end else begin
                core_r     <= core_r;
                core_sym_r <= core_sym_r;
            end
        end
    end

    // Tag pipe fed from the issue register so its last stage lines up with core_out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CORE_LAT; k++) tag_r[k] <= '0;
        end else begin
            tag_r[0] <= {core_in_valid_r, core_sym_r};
            for (int k = 1; k < CORE_LAT; k++) tag_r[k] <= tag_r[k-1];
        end
    end

    // Nothing issued and nothing pending in the tag pipe.
    always_comb begin
        pipe_empty_s = !core_in_valid_r;
        for (int k = 0; k < CORE_LAT; k++) pipe_empty_s = pipe_empty_s & !tag_r[k].vld;
    end

    // Release/throttle decision; a decision in the wrap cycle belongs to the new window.
    always_comb begin
        hit_s    = bus.core_out_valid && tag_r[CORE_LAT-1].vld;
        dec_s    = bus.core_buy || bus.core_sell;
        squash_s = (state_r == ST_HALT) || kill_r;
        wrap_s   = (win_r == WIN_LAST);
        rel_s    = 1'b0;
        thr_s    = 1'b0;
        if (hit_s && dec_s) begin
            if (squash_s)              thr_s = 1'b1;
            else if (wrap_s)           rel_s = 1'b1;
            else if (rc_r == RC_FULL)  thr_s = 1'b1;
            else                       rel_s = 1'b1;
        end else begin
            rel_s = 1'b0;
        end
        if (wrap_s)     rc_nxt_s = rel_s ? RC_W'(1) : '0;
        else if (rel_s) rc_nxt_s = rc_r + RC_W'(1);
        else            rc_nxt_s = rc_r;
    end

    // Window counter and rate count.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_r <= '0;
            rc_r  <= '0;
        end else begin
            win_r <= wrap_s ? '0 : win_r + WIN_W'(1);
            rc_r  <= rc_nxt_s;
        end
    end

    // Registered result stage; untagged core strobes are dropped here.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_r <= 1'b0;
            res_sym_r   <= '0;
            res_buy_r   <= 1'b0;
            res_sell_r  <= 1'b0;
            res_thr_r   <= 1'b0;
        end else begin
            res_valid_r <= hit_s;
            res_sym_r   <= hit_s ? tag_r[CORE_LAT-1].sym : '0;
            res_buy_r   <= rel_s && bus.core_buy;
            res_sell_r  <= rel_s && bus.core_sell;
            res_thr_r   <= thr_s;
        end
    end

    assign bus.req_ready     = gnt_s;
    assign bus.core_bid      = core_r.bid;
    assign bus.core_ask      = core_r.ask;
    assign bus.core_fair     = core_r.fair;
    assign bus.core_vol      = core_r.vol;
    assign bus.core_inv      = core_r.inv;
    assign bus.core_in_valid = core_in_valid_r;
    assign bus.res_valid     = res_valid_r;
    assign bus.res_sym       = res_sym_r;
    assign bus.res_buy       = res_buy_r;
    assign bus.res_sell      = res_sell_r;
    assign bus.res_throttled = res_thr_r;
    assign bus.state_o       = state_r;

endmodule

// File: tb/tb_strat_sched.sv
// Bench for strat_sched: behavioural 4-cycle core model, scoreboard of expected
// results keyed by accept cycle, a vector table and hand-written corner sequences.
module tb_strat_sched;
    import strat_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    strat_sched_if sif ();
    strat_sched dut (.clk(clk), .rst(rst), .bus(sif));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: buy when fair above ask, sell when fair below bid, 4-cycle latency.
    logic [3:0] cm_v = 4'b0000;
    logic [3:0] cm_b = 4'b0000;
    logic [3:0] cm_s = 4'b0000;
    always @(posedge clk) begin
        cm_v <= {cm_v[2:0], sif.core_in_valid};
        cm_b <= {cm_b[2:0], ($signed(sif.core_fair) > $signed(sif.core_ask))};
        cm_s <= {cm_s[2:0], ($signed(sif.core_fair) < $signed(sif.core_bid))};
    end
    assign sif.core_out_valid = cm_v[3];
    assign sif.core_buy       = cm_b[3];
    assign sif.core_sell      = cm_s[3];

    int errs   = 0;
    int checks = 0;

    typedef struct {
        int   sym;
        logic buy;
        logic sell;
        logic thr;
        int   cyc;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    logic sym_eb [4];
    logic sym_es [4];

    typedef struct {
        int          sym;
        logic [31:0] bid;
        logic [31:0] ask;
        logic [31:0] fair;
        logic        eb;
        logic        es;
    } vec_t;
    vec_t tab [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result monitor: every res_valid must match the oldest expected entry, cycle included.
    always @(negedge clk) begin
        if (!rst && sif.res_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_result: got res_valid sym=%0d at cycle %0d expected none",
                         sif.res_sym, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                if (int'(sif.res_sym) != mon_e.sym || sif.res_buy !== mon_e.buy ||
                    sif.res_sell !== mon_e.sell || sif.res_throttled !== mon_e.thr ||
                    cyc != mon_e.cyc) begin
                    errs++;
                    $display("FAIL result: got sym=%0d buy=%0b sell=%0b thr=%0b cyc=%0d expected sym=%0d buy=%0b sell=%0b thr=%0b cyc=%0d",
                             sif.res_sym, sif.res_buy, sif.res_sell, sif.res_throttled, cyc,
                             mon_e.sym, mon_e.buy, mon_e.sell, mon_e.thr, mon_e.cyc);
                end
            end
        end
    end

    task automatic push(input int s, input logic b, input logic se, input logic t);
        sb_q.push_back('{s, b, se, t, cyc + 6});
    endtask

    task automatic set_req(input int s, input logic [31:0] b, input logic [31:0] a,
                           input logic [31:0] f, input logic eb, input logic es);
        sif.req_valid[s] = 1'b1;
        sif.req_bid[s*W +: W]  = b;
        sif.req_ask[s*W +: W]  = a;
        sif.req_fair[s*W +: W] = f;
        sif.req_vol[s*W +: W]  = 32'd0;
        sif.req_inv[s*W +: W]  = 32'd0;
        sym_eb[s] = eb;
        sym_es[s] = es;
    endtask

    // Reset pulse; ends at the negedge of the first cycle with rst low and returns that cycle.
    task automatic do_reset(input logic en, output int rcyc);
        @(negedge clk);
        rst = 1'b1;
        sif.req_valid = 4'b0000;
        sif.kill = 1'b0;
        sif.enable = en;
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rcyc = cyc;
    endtask

    task automatic issue_one(input int s, input logic [31:0] b, input logic [31:0] a,
                             input logic [31:0] f, input logic eb, input logic es, input logic et);
        bit ok;
        ok = 1'b0;
        set_req(s, b, a, f, eb, es);
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            if (sif.req_ready[s]) begin
                push(s, et ? 1'b0 : eb, et ? 1'b0 : es, et);
                ok = 1'b1;
            end
            @(negedge clk);
        end
        sif.req_valid[s] = 1'b0;
        if (!ok) begin
            checks++;
            errs++;
            $display("FAIL issue_timeout: got no req_ready for sym %0d expected grant", s);
        end
    endtask

    // n consecutive grants expected in RR order starting at 'first'; squash marks kill-time results.
    task automatic burst(input int n, input int first, input logic push_en, input logic squash);
        logic [3:0] oh;
        int idx;
        for (int k = 0; k < n; k++) begin
            #1;
            idx = (first + k) % 4;
            oh = 4'b0001 << idx;
            chk("rr_grant", 64'(sif.req_ready), 64'(oh));
            if (push_en)
                push(idx, squash ? 1'b0 : sym_eb[idx], squash ? 1'b0 : sym_es[idx],
                     squash & (sym_eb[idx] | sym_es[idx]));
            @(negedge clk);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb_q.size() > 0; k++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errs++;
            $display("FAIL drain: got %0d results outstanding expected 0", sb_q.size());
        end
    endtask

    int r0;
    int n;

    initial begin
        sif.enable = 1'b0;
        sif.kill = 1'b0;
        sif.req_valid = 4'b0000;
        sif.req_bid = '0;
        sif.req_ask = '0;
        sif.req_fair = '0;
        sif.req_vol = '0;
        sif.req_inv = '0;
        for (int i = 0; i < 4; i++) begin
            sym_eb[i] = 1'b0;
            sym_es[i] = 1'b0;
        end

        tab[0] = '{2, 32'd25600, 32'd25856, 32'd26880, 1'b1, 1'b0};
        tab[1] = '{0, 32'd30000, 32'd30100, 32'd29000, 1'b0, 1'b1};
        tab[2] = '{1, 32'd1000,  32'd1010,  32'd1005,  1'b0, 1'b0};
        tab[3] = '{3, 32'd500,   32'd600,   32'd700,   1'b1, 1'b0};
        tab[4] = '{2, 32'hFFFFFF00, 32'hFFFFFF38, 32'hFFFFFF9C, 1'b1, 1'b0};
        tab[5] = '{1, 32'd100,   32'd200,   32'd50,    1'b0, 1'b1};

        // Reset state, then IDLE->RUN with enable.
        do_reset(1'b1, r0);
        chk("rst_state", 64'(sif.state_o), 64'd0);
        chk("rst_core_in_valid", 64'(sif.core_in_valid), 64'd0);
        chk("rst_res_valid", 64'(sif.res_valid), 64'd0);
        chk("rst_req_ready", 64'(sif.req_ready), 64'd0);
        @(negedge clk);
        chk("run_state", 64'(sif.state_o), 64'd1);

        // Vector table: single requests, core pulse one cycle after accept, result six after.
        for (int v = 0; v < 6; v++) begin
            issue_one(tab[v].sym, tab[v].bid, tab[v].ask, tab[v].fair, tab[v].eb, tab[v].es, 1'b0);
            chk("core_in_valid", 64'(sif.core_in_valid), 64'd1);
            chk("core_bid", 64'(sif.core_bid), 64'(tab[v].bid));
            chk("core_fair", 64'(sif.core_fair), 64'(tab[v].fair));
            @(negedge clk);
            chk("core_in_valid_pulse", 64'(sif.core_in_valid), 64'd0);
            chk("core_ask_hold", 64'(sif.core_ask), 64'(tab[v].ask));
            drain();
        end

        // All four requesting for 8 cycles: grants and results 0,1,2,3,0,1,2,3.
        do_reset(1'b1, r0);
        @(negedge clk);
        set_req(0, 32'd500, 32'd600, 32'd700, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) set_req(i, 32'd1000, 32'd1010, 32'd1005, 1'b0, 1'b0);
        burst(8, 0, 1'b1, 1'b0);
        sif.req_valid = 4'b0000;
        drain();

        // Rate limit: 10 buys, last two throttled.
        do_reset(1'b1, r0);
        @(negedge clk);
        set_req(1, 32'd500, 32'd600, 32'd700, 1'b1, 1'b0);
        n = 0;
        for (int k = 0; k < 40 && n < 10; k++) begin
            #1;
            if (sif.req_ready[1]) begin
                push(1, n < 8, 1'b0, n >= 8);
                n++;
            end
            @(negedge clk);
        end
        sif.req_valid[1] = 1'b0;
        chk("rate_accepts", 64'(n), 64'd10);
        drain();

        // Buy landing on the wrap cycle is released although the old window is full.
        while (cyc < r0 + 1018) @(negedge clk);
        issue_one(1, 32'd500, 32'd600, 32'd700, 1'b1, 1'b0, 1'b0);
        drain();
        // That buy counted as 1 in the new window: 7 more released, the 8th throttled.
        set_req(1, 32'd500, 32'd600, 32'd700, 1'b1, 1'b0);
        n = 0;
        for (int k = 0; k < 40 && n < 8; k++) begin
            #1;
            if (sif.req_ready[1]) begin
                push(1, n < 7, 1'b0, n == 7);
                n++;
            end
            @(negedge clk);
        end
        sif.req_valid[1] = 1'b0;
        chk("rate_accepts2", 64'(n), 64'd8);
        drain();

        // Kill with three in flight.
        do_reset(1'b1, r0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) set_req(i, 32'd500, 32'd600, 32'd700, 1'b1, 1'b0);
        burst(3, 0, 1'b1, 1'b1);
        sif.req_valid = 4'b0000;
        sif.kill = 1'b1;
        @(negedge clk);
        set_req(3, 32'd500, 32'd600, 32'd700, 1'b1, 1'b0);
        chk("halt_state", 64'(sif.state_o), 64'd2);
        #1;
        chk("kill_no_grant", 64'(sif.req_ready), 64'd0);
        @(negedge clk);
        #1;
        chk("kill_no_grant", 64'(sif.req_ready), 64'd0);
        @(negedge clk);
        sif.kill = 1'b0;
        sif.enable = 1'b0;
        #1;
        chk("kill_no_grant", 64'(sif.req_ready), 64'd0);
        @(negedge clk);
        chk("halt_while_busy", 64'(sif.state_o), 64'd2);
        for (int k = 0; k < 20 && sif.state_o != 2'd0; k++) @(negedge clk);
        chk("halt_to_idle", 64'(sif.state_o), 64'd0);
        sif.req_valid = 4'b0000;
        drain();

        // Reset with two in flight: outputs cleared, late core strobes dropped.
        do_reset(1'b1, r0);
        @(negedge clk);
        set_req(0, 32'd500, 32'd600, 32'd700, 1'b1, 1'b0);
        set_req(1, 32'd500, 32'd600, 32'd700, 1'b1, 1'b0);
        burst(2, 0, 1'b0, 1'b0);
        sif.req_valid = 4'b0000;
        sif.enable = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_core_in_valid", 64'(sif.core_in_valid), 64'd0);
        chk("midrst_core_bid", 64'(sif.core_bid), 64'd0);
        chk("midrst_res_valid", 64'(sif.res_valid), 64'd0);
        chk("midrst_state", 64'(sif.state_o), 64'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("midrst_no_result", 64'(sif.res_valid), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/strat_sched.md
Name: strat_sched

Overview:
- Time-shares one strat_decide inference core among N_SYM symbol channels.
- Arbitrates per-symbol snapshot requests round-robin and drives the core's input registers.
- Tags each issue with its symbol id and realigns results through the core's fixed 4-cycle latency.
- Applies a global order-rate limiter and a kill switch before results reach order entry.

Parameters:
- W, 32, price/state word width (matches the core).
- N_SYM, 4, number of symbol requesters; power of 2, minimum 2.
- TAG_W, 2, symbol id width; equals clog2(N_SYM).
- CORE_LAT, 4, cycles from core_in_valid to core_out_valid.
- RATE_WIN, 1024, rate-limit window length in cycles.
- RATE_MAX, 8, maximum buy/sell decisions released per window.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  scheduler run enable
- kill  in  1  kill switch: stop issuing, squash decisions
- req_valid  in  N_SYM  per-symbol snapshot valid
- req_ready  out  N_SYM  per-symbol accept (combinational grant)
- req_bid, req_ask, req_fair, req_vol  in  N_SYM*W  packed per-symbol BBO, fair price, volatility
- req_inv  in  N_SYM*W  packed signed per-symbol inventory
- core_bid, core_ask, core_fair, core_vol, core_inv  out  W each  registered core inputs
- core_in_valid  out  1  core trigger
- core_buy, core_sell, core_out_valid  in  1 each  core results
- res_valid  out  1  result strobe
- res_sym  out  TAG_W  symbol of result
- res_buy, res_sell  out  1 each  released decisions
- res_throttled  out  1  decision suppressed by limiter or kill
- state_o  out  2  FSM state (IDLE=0, RUN=1, HALT=2)

Behaviour:
- Reset: all outputs 0; FSM=IDLE; RR pointer=0; tag pipe, window counter and rate count cleared. Reset mid-flight discards in-flight tags; a core_out_valid seen afterwards with no matching tag is ignored (res_valid stays 0).
- FSM transitions:
  - IDLE->RUN when enable=1 and kill=0.
  - RUN->HALT when kill=1.
  - RUN->IDLE when enable=0.
  - HALT->IDLE when kill=0 and the tag pipe is empty.
  - kill has priority over enable.
- Grant: only in RUN. Exactly one req_ready bit is high: the first requesting index at or after the RR pointer. req_ready is 0 when no request is pending or the state is not RUN. One grant per cycle.
- Pointer update: on an accept of index i, the pointer becomes (i+1) mod N_SYM. The pointer holds when there is no accept.
- Issue: an accept in cycle T registers the selected fields onto the core_* outputs; core_in_valid=1 in T+1, otherwise 0. core_* data holds its last value when idle.
- Tag pipe: CORE_LAT-deep shift of {valid, sym}, aligned so the tag exits with core_out_valid in T+5.
- Result: registered; res_* is valid in T+6 (accept-to-result latency 6). Back-to-back issue gives one result per cycle.
- Rate limiter:
  - Window counter counts 0..RATE_WIN-1 and wraps.
  - Rate count increments on each released decision (res_buy|res_sell).
  - When rate count = RATE_MAX, a decision is output as res_buy=res_sell=0 with res_throttled=1.
  - On wrap, rate count reloads to 0. If a decision arrives in the wrap cycle, it counts in the new window (count becomes 1).
- Kill: takes effect the cycle after it is sampled high. No new grants. In-flight results still emit res_valid with buy/sell forced 0 and res_throttled=1; squashed results do not increment the rate count.
- No-decision results (core_buy=core_sell=0) emit res_valid with res_throttled=0.
- Width rules: no arithmetic on prices; pure selection. Rate count is clog2(RATE_MAX+1) bits and saturates.

Decomposition:
- Shared package strat_pkg: state enum, CORE_LAT, N_SYM/TAG_W defaults, typedef for the packed per-symbol snapshot struct.
- Sub-module strat_rr_arb: N-way round-robin arbiter with one-hot grant and pointer register.
- Tag pipe, FSM and rate limiter stay in strat_sched.

Test Plan:
- Single request, with the real core: bid=25600, ask=25856, fair=26880, inv=0, vol=0 on sym 2 -> core_in_valid 1 cycle after accept; res_valid, res_sym=2, res_buy=1 exactly 6 cycles after accept.
- All four req_valid held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3; results in the same order, one per cycle, with matching res_sym.
- RATE_MAX=8, 10 buy-generating requests in one window -> first 8 res_buy=1; 9th and 10th res_buy=0 with res_throttled=1. Decisions after the window wraps are released again.
- Buy decision arriving exactly on the window-wrap cycle -> released; rate count reads 1 afterwards.
- kill asserted with 3 results in flight -> no further req_ready; 3 res_valid with buy=0 and throttled=1; HALT until kill=0 and pipe empty, then IDLE.
- rst pulsed with 2 in flight -> all outputs 0 next cycle; the late core_out_valid pulses produce no res_valid.
